bf_iteration_scheduler: RTL and testbench

//  Pass-level sequencer for the Bellman-Ford processing block (DATAPATH + AGU).
//  - Drives read_enable/write_enable for each relaxation phase.
//  - Counts completed passes over the edge memory.
//  - Terminates early when a full pass relaxes no distance, otherwise after MAX_ITER passes.
//  - Reports finish, converged and the pass count to the host.

---
 rtl/bf_iteration_scheduler.sv | 163 ++++++++++++++++
 tb/tb_bf_iteration_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_iteration_scheduler.sv
// Pass-level sequencer for the Bellman-Ford block.
// Walks each pass through READ/WRITE phases, counts passes, and stops
// when a pass relaxes nothing or when MAX_ITER passes have run.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// READ   | read/compare phase, read_enable held READ_CYCLES cycles
// WRITE  | one-cycle write-back phase, samples iteration_done
// CHECK  | end of pass: decide DONE (converged / limit) or next pass
// DONE   | finish high, results held until start drops
module bf_iteration_scheduler #(
  parameter int NUM_NODES   = 16,
  parameter int MAX_ITER    = NUM_NODES - 1,
  parameter int READ_CYCLES = 2,
  parameter int ITER_W      = 5
) (
  input  logic              clk,
  input  logic              rst_global,
  input  logic              start,
  input  logic              iteration_done,
  input  logic              update_seen,
  output logic              read_enable,
  output logic              write_enable,
  output logic              busy,
  output logic              finish,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam int PH_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
  localparam logic [PH_W-1:0]   PH_LOAD   = PH_W'(READ_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PH_W-1:0]   phase_cnt;
  logic              dirty;
  logic              pass_dirty;
  logic              ph_load;
  logic              run_start;
  logic              pass_next;
  logic              end_conv;
  logic              end_limit;

  // Next-state decode and the one-cycle strobes that update the counters.
  always_comb begin
    state_nxt  = state;
    ph_load    = 1'b0;
    run_start  = 1'b0;
    pass_next  = 1'b0;
    end_conv   = 1'b0;
    end_limit  = 1'b0;
    // A relaxation seen in the CHECK cycle still belongs to this pass.
    pass_dirty = dirty | update_seen;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
          run_start = 1'b1;
          ph_load   = 1'b1;
        end
      end
      S_READ: begin
        if (phase_cnt == '0) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (iteration_done) begin
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_READ;
          ph_load   = 1'b1;
        end
      end
      S_CHECK: begin
        if (!pass_dirty) begin
          state_nxt = S_DONE;
          end_conv  = 1'b1;
        end else if (iter_count == ITER_LAST) begin
          state_nxt = S_DONE;
          end_limit = 1'b1;
        end else begin
          state_nxt = S_READ;
          pass_next = 1'b1;
          ph_load   = 1'b1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // READ phase down-counter; WRITE is entered when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      phase_cnt <= '0;
    end else if (ph_load) begin
      phase_cnt <= PH_LOAD;
    end else if (state == S_READ && phase_cnt != '0) begin
      phase_cnt <= phase_cnt - 1'b1;
    end
  end

  // Per-pass relaxation flag, cleared at the start of each pass.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      dirty <= 1'b0;
    end else if (run_start || pass_next) begin
      dirty <= 1'b0;
    end else if ((state == S_READ || state == S_WRITE) && update_seen) begin
      dirty <= 1'b1;
    end
  end

  // Pass count and exit reason; the count stops at MAX_ITER by construction.
  always_ff @(posedge clk) begin
    if (rst_global) begin
      iter_count <= '0;
      converged  <= 1'b0;
    end else if (run_start) begin
      iter_count <= '0;
      converged  <= 1'b0;
    end else if (end_conv) begin
      iter_count <= iter_count + 1'b1;
      converged  <= 1'b1;
    end else if (end_limit) begin
      iter_count <= ITER_MAX;
      converged  <= 1'b0;
    end else if (pass_next) begin
      iter_count <= iter_count + 1'b1;
    end
  end

  assign read_enable  = (state == S_READ);
  assign write_enable = (state == S_WRITE);
  assign busy         = (state == S_READ) || (state == S_WRITE) || (state == S_CHECK);
  assign finish       = (state == S_DONE);

endmodule

// File: tb/tb_bf_iteration_scheduler.sv
// Bench for bf_iteration_scheduler. Each run is described as a list of
// passes (phases per pass, whether the pass relaxes anything); the expected
// per-cycle output table is built from that description and replayed.
module tb_bf_iteration_scheduler;

  localparam int MI = 15;
  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       rst_global;
  logic       start;
  logic       iteration_done;
  logic       update_seen;
  logic       read_enable;
  logic       write_enable;
  logic       busy;
  logic       finish;
  logic       converged;
  logic [4:0] iter_count;

  bf_iteration_scheduler #(
    .NUM_NODES(16), .MAX_ITER(MI), .READ_CYCLES(RC), .ITER_W(5)
  ) dut (
    .clk(clk), .rst_global(rst_global), .start(start),
    .iteration_done(iteration_done), .update_seen(update_seen),
    .read_enable(read_enable), .write_enable(write_enable), .busy(busy),
    .finish(finish), .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       idone;
    logic       upd;
    logic       re;
    logic       we;
    logic       bsy;
    logic       fin;
    logic       conv;
    logic [4:0] iter;
  } vec_t;

  vec_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         pass_phases[MI];
  bit         pass_dirty[MI];
  int         upd_mode;
  int         done_hold;
  logic [4:0] last_iter;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic id, input logic u, input logic re,
                     input logic we, input logic b, input logic f, input logic c,
                     input logic [4:0] it);
    vec_t v;
    v.start = s; v.idone = id; v.upd = u; v.re = re; v.we = we;
    v.bsy = b; v.fin = f; v.conv = c; v.iter = it;
    q.push_back(v);
  endtask

  // Builds one run: start in IDLE, passes, DONE hold, return to IDLE.
  task automatic gen_run();
    int   ncyc, pos, idx;
    logic conv;
    logic [4:0] fin_iter;
    conv = 1'b0;
    fin_iter = 5'd0;
    add(1'b1, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 0, 0, last_iter);
    for (int k = 0; k < MI; k++) begin
      ncyc = pass_phases[k] * (RC + 1) + 1;
      pos  = (upd_mode == 1) ? ncyc - 1 : $urandom_range(0, ncyc - 1);
      idx  = 0;
      for (int p = 0; p < pass_phases[k]; p++) begin
        for (int r = 0; r < RC; r++) begin
          add(1'($urandom % 2), 1'($urandom % 2), pass_dirty[k] && idx == pos,
              1, 0, 1, 0, 0, 5'(k));
          idx++;
        end
        add(1'($urandom % 2), p == pass_phases[k] - 1, pass_dirty[k] && idx == pos,
            0, 1, 1, 0, 0, 5'(k));
        idx++;
      end
      add(1'($urandom % 2), 1'($urandom % 2), pass_dirty[k] && idx == pos,
          0, 0, 1, 0, 0, 5'(k));
      if (!pass_dirty[k]) begin
        conv = 1'b1; fin_iter = 5'(k + 1);
        break;
      end else if (k == MI - 1) begin
        conv = 1'b0; fin_iter = 5'(MI);
      end
    end
    last_iter = fin_iter;
    for (int h = 0; h < done_hold; h++)
      add(1'b1, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 1, conv, fin_iter);
    add(1'b0, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 1, conv, fin_iter);
    for (int g = 0, n = $urandom_range(0, 2); g < n; g++)
      add(1'b0, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 0, 0, fin_iter);
  endtask

  // Entered and left at posedge+1; outputs checked on the falling edge.
  task automatic apply_q();
    foreach (q[i]) begin
      start = q[i].start; iteration_done = q[i].idone; update_seen = q[i].upd;
      @(negedge clk);
      chk("read_enable",  i, 32'(read_enable),  32'(q[i].re));
      chk("write_enable", i, 32'(write_enable), 32'(q[i].we));
      chk("busy",         i, 32'(busy),         32'(q[i].bsy));
      chk("finish",       i, 32'(finish),       32'(q[i].fin));
      chk("iter_count",   i, 32'(iter_count),   32'(q[i].iter));
      if (q[i].fin) chk("converged", i, 32'(converged), 32'(q[i].conv));
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_re"},   0, 32'(read_enable),  0);
    chk({name, "_we"},   0, 32'(write_enable), 0);
    chk({name, "_busy"}, 0, 32'(busy),         0);
    chk({name, "_fin"},  0, 32'(finish),       0);
    chk({name, "_conv"}, 0, 32'(converged),    0);
    chk({name, "_iter"}, 0, 32'(iter_count),   0);
  endtask

  task automatic set_plan(input int phases, input int dirty_passes);
    for (int k = 0; k < MI; k++) begin
      pass_phases[k] = (phases > 0) ? phases : $urandom_range(1, 3);
      pass_dirty[k]  = (k < dirty_passes);
    end
  endtask

  initial begin
    rst_global = 1'b1; start = 1'b0; iteration_done = 1'b0; update_seen = 1'b0;
    last_iter = 5'd0; upd_mode = 0; done_hold = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1;
    rst_global = 1'b0;

    // Clean run: 3 phases, nothing relaxed -> converged after 1 pass.
    set_plan(3, 0); gen_run(); apply_q();

    // Reset pulsed mid-READ, then a fresh run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("midread_re", 0, 32'(read_enable), 1);
    rst_global = 1'b1;
    @(posedge clk); #1;
    rst_global = 1'b0;
    @(negedge clk);
    chk_idle_zero("midread_rst");
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_rst_busy", 0, 32'(busy), 0);
    @(posedge clk); #1;
    last_iter = 5'd0;
    set_plan(1, 0); gen_run(); apply_q();

    // Every pass relaxes -> stops at MAX_ITER, not converged.
    set_plan(1, MI); gen_run(); apply_q();
    rst_global = 1'b1;
    @(posedge clk); #1;
    rst_global = 1'b0;
    @(negedge clk);
    chk_idle_zero("idle_rst");
    @(posedge clk); #1;
    last_iter = 5'd0;

    // Relaxations in passes 1-4 only -> converged at 5.
    set_plan(0, 4); gen_run(); apply_q();

    // Relaxation only in CHECK of pass 1 -> pass 2 runs.
    upd_mode = 1; set_plan(2, 1); gen_run(); apply_q(); upd_mode = 0;

    // Long start hold through DONE.
    done_hold = 6; set_plan(1, 2); gen_run(); apply_q();

    // Randomised runs.
    for (int r = 0; r < 30; r++) begin
      upd_mode  = $urandom_range(0, 1);
      done_hold = $urandom_range(0, 3);
      set_plan(0, $urandom_range(0, MI + 1));
      gen_run();
      apply_q();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
